// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle unsigned ALU (add/sub 1 cycle, mul/div WIDTH cycles) with valid/ready handshakes
// Ports: clk, rst (async, active-high); in_valid/in_ready + a, b, op (00 add, 01 sub, 10 mul, 11 div);
//        out_valid/out_ready + result (2*WIDTH); busy (RUN or DONE).
// Optional: define ALU_STATUS_FLAGS_EN to add flags[2:0] = {div_by_zero, carry/borrow, zero}.
module seq_alu_core #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic [2:0]         flags
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state;
  logic [WIDTH-1:0] hi, lo, b_r, hi_n, lo_n;
  logic div_r, ge;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, madd, shl, dsub;
  logic [2*WIDTH-1:0] quick;
  // hi/lo double as {accumulator, multiplier} for mul and {remainder, quotient} for div,
  // so the finished result is always {hi, lo}.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    quick = op[0] ? {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b} : {{(WIDTH-1){1'b0}}, sum};
    madd = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    shl = {hi, lo[WIDTH-1]};
    ge = shl >= {1'b0, b_r};
    dsub = shl - {1'b0, b_r};
    hi_n = div_r ? (ge ? dsub[WIDTH-1:0] : shl[WIDTH-1:0]) : madd[WIDTH:1];
    lo_n = div_r ? {lo[WIDTH-2:0], ge} : {madd[0], lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      b_r <= '0;
      div_r <= 1'b0;
      cnt <= '0;
      result <= '0;
`ifdef ALU_STATUS_FLAGS_EN
      flags <= '0;
`endif
    end else if (state == IDLE) begin
      if (in_valid) begin
        if (op[1]) begin
          hi <= '0;
          lo <= a;
          b_r <= b;
          div_r <= op[0];
          cnt <= CW'(WIDTH);
          state <= RUN;
        end else begin
          result <= quick;
          state <= DONE;
`ifdef ALU_STATUS_FLAGS_EN
          flags <= {1'b0, op[0] ? (a < b) : sum[WIDTH], quick == '0};
`endif
        end
      end
    end else if (state == RUN) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt - CW'(1);
      // the last step lands directly in DONE so out_valid rises WIDTH+1 cycles after accept
      if (cnt == CW'(1)) begin
        state <= DONE;
        result <= {hi_n, lo_n};
`ifdef ALU_STATUS_FLAGS_EN
        flags <= {div_r && b_r == '0, 1'b0, {hi_n, lo_n} == '0};
`endif
      end
    end else if (out_ready) state <= IDLE;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: randomized self-checking bench for seq_alu_core against a latency/arithmetic model
module tb_seq_alu_core;
  localparam int W = 3;
  localparam int Q = 1 << W;
  localparam int M = 1 << (2 * W);
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b;
  logic [1:0] op;
  logic [2*W-1:0] result;
`ifdef ALU_STATUS_FLAGS_EN
  logic [2:0] flags;
`endif
  int n_cmp = 0, n_bad = 0;
  seq_alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
`ifdef ALU_STATUS_FLAGS_EN
    , .flags(flags)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: an accepted op becomes visible after a fixed latency, then waits for out_ready
  bit m_busy, m_valid;
  int m_res, m_flags, p_res, p_flags, left;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_res = 0; m_flags = 0; left = 0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_busy = 0; end
    end else if (m_busy) begin
      left--;
      if (left == 0) begin m_valid = 1; m_res = p_res; m_flags = p_flags; end
    end else if (in_valid) begin
      int ia, ib, c, dz;
      ia = int'(a); ib = int'(b); c = 0; dz = 0;
      case (op)
        2'd0: begin p_res = ia + ib; c = int'(ia + ib >= Q); end
        2'd1: begin p_res = (ia - ib + M) % M; c = int'(ia < ib); end
        2'd2: p_res = ia * ib;
        default: begin
          p_res = (ib == 0) ? ia * Q + (Q - 1) : (ia % ib) * Q + ia / ib;
          dz = int'(ib == 0);
        end
      endcase
      p_flags = dz * 4 + c * 2 + int'(p_res == 0);
      m_busy = 1;
      left = (op[1] ? W + 1 : 1) - 1;
      if (left == 0) begin m_valid = 1; m_res = p_res; m_flags = p_flags; end
    end
  end
  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_valid);
      chk("result", result, m_res);
`ifdef ALU_STATUS_FLAGS_EN
      chk("flags", flags, m_flags);
`endif
    end
  task automatic run_op(input int ta, input int tb, input int top, input int exp_res, input int exp_lat, input string nm);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    a = W'(ta); b = W'(tb); op = 2'(top); in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_res"}, result, exp_res);
    @(posedge clk); #1;
    chk({nm, "_drop"}, out_valid, 0);
  endtask
  initial begin
    int n;
    rst = 1; in_valid = 0; out_ready = 1; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    rst = 0;
    run_op(7, 7, 0, 14, 1, "add77");
    run_op(2, 5, 1, 61, 1, "sub25");
`ifdef ALU_STATUS_FLAGS_EN
    chk("sub25_flags", flags, 3'b010);
`endif
    run_op(7, 6, 2, 42, W + 1, "mul76");
    run_op(7, 2, 3, 11, W + 1, "div72");
    run_op(5, 0, 3, 47, W + 1, "div50");
`ifdef ALU_STATUS_FLAGS_EN
    chk("div50_flags", flags, 3'b100);
`endif
    run_op(0, 0, 0, 0, 1, "add00");
    run_op(7, 7, 2, 49, W + 1, "mul77");
    // backpressure: mul 3*3 held in DONE, in_valid pulsed meanwhile
    @(negedge clk);
    a = 3; b = 3; op = 2; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 1); a = 1; b = 1; op = 0;
      chk("hold_res", result, 9);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 1; a = 1; b = 1; op = 0;
    @(posedge clk); #1;
    chk("release_idle", in_ready, 1);
    chk("release_drop", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("after_add_valid", out_valid, 1);
    chk("after_add_res", result, 2);
    // async reset two cycles into a div
    @(negedge clk);
    a = 7; b = 3; op = 3; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    run_op(1, 1, 0, 2, 1, "post_rst");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1) == 1;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
Parametrised multi-cycle ALU, the successor to the fixed 3-bit combinational arithmetic unit on the Tiny Tapeout pinout. It performs add, subtract, multiply and divide on WIDTH-bit unsigned operands and returns a 2*WIDTH-bit result. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles. A valid/ready handshake sits on both input and output so the top-level wrapper can drive it from ui_in/uio_in and apply backpressure.

Parameters:
WIDTH, 3, operand width in bits; legal range 2..16; result width is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  operands and op are presented.
in_ready  output  1  block can accept a new operation.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
out_valid  output  1  result is valid and held.
out_ready  input  1  consumer takes the result.
result  output  2*WIDTH  operation result.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal registers 0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and op.
    - op 00/01: compute and go to DONE. out_valid rises 1 cycle after accept.
    - op 10/11: load the iteration counter with WIDTH and go to RUN.
  - RUN: one multiply or divide step per cycle. After exactly WIDTH steps go to DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE: out_valid=1 and result held stable. On out_ready, go to IDLE next cycle and drop out_valid.
- in_ready=0 in RUN and DONE; in_valid there is ignored. There are no overlapping operations.
- Operands are registered at accept. Input changes after accept have no effect.
- Arithmetic:
  - add: zero-extended a+b.
  - sub: (a-b) mod 2^(2*WIDTH), i.e. the WIDTH+1-bit difference sign-extended.
  - mul: unsigned a*b, full 2*WIDTH bits.
  - div: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
  - div with b=0: quotient all ones, remainder = a; still takes WIDTH+1 cycles.
- In DONE, result changes only on leaving DONE. In IDLE, result keeps its last value.
- Reset asserted mid-RUN or mid-DONE: outputs go to reset values immediately and the operation is lost.
- Simultaneous out_ready with in_valid in DONE: out_ready is honoured and in_valid is ignored. The new operation is accepted no earlier than the following IDLE cycle.
- Counter width: clog2(WIDTH+1) bits. No wrap-around is possible.

Optional Feature:
Macro ALU_STATUS_FLAGS_EN.
- Defined: extra output port flags[2:0], registered with result and valid under the same out_valid.
  - flags[0] zero: result==0.
  - flags[1] carry/borrow: add carry-out or sub borrow.
  - flags[2] div_by_zero: op 11 with b=0.
  - flags reset to 0.
- Undefined: the flags port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=3, add a=7 b=7, out_ready=1 -> result=14 (6'b001110), out_valid 1 cycle after accept for exactly 1 cycle.
2. sub a=2 b=5 -> result=61 (6'b111101). With ALU_STATUS_FLAGS_EN, flags=3'b010.
3. mul a=7 b=6 -> result=42, out_valid 4 cycles after accept, in_ready=0 throughout RUN.
4. div a=7 b=2 -> result=11 ({r=1,q=3}). div a=5 b=0 -> result=47 ({5,7}); with macro, flags[2]=1.
5. mul a=3 b=3 with out_ready held low 5 cycles and in_valid pulsed during DONE -> result=9 held stable, pulse not accepted, IDLE one cycle after out_ready rises.
6. Assert rst 2 cycles into a div -> out_valid=0, busy=0, result=0 asynchronously. After release, add a=1 b=1 -> result=2.
